operand_stack: RTL and testbench

OPERAND_STACK -- requirements
Module: operand_stack

---
 rtl/stack_pkg.sv | 18 +
 rtl/stack_storage.sv | 53 +++++
 rtl/operand_stack.sv | 145 ++++++++++++++
 tb/tb_operand_stack.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: op codes and default geometry.
package stack_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   typedef enum logic [2:0] {
      NOP   = 3'd0,
      PUSH  = 3'd1,
      POP   = 3'd2,
      BINOP = 3'd3,
      REPL  = 3'd4,
      DUP   = 3'd5,
      SWAP  = 3'd6,
      RSVD  = 3'd7
   } stk_op_t;

endpackage

// File: rtl/stack_storage.sv
// Backing store for entries below pen: write at ptr, combinational read at ptr-1.
module stack_storage
   import stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 2);

   logic [WIDTH-1:0] mem_r [0:DEPTH-2];
   logic [PW-1:0]    ptr_r;
   logic [PW-1:0]    rd_idx_s;

   // Pointer saturates at both ends so an out-of-range request can never wrap it.
   always_ff @(posedge clk) begin
      if (clr) begin
         ptr_r <= {PW{1'b0}};
      end else if (push && (ptr_r < PTR_MAX)) begin
         ptr_r <= ptr_r + PW'(1);
      end else if (pop && (ptr_r != {PW{1'b0}})) begin
         ptr_r <= ptr_r - PW'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Entry array is never cleared; slots at or above ptr are simply ignored.
   always_ff @(posedge clk) begin
      if (!clr && push && (ptr_r <= PTR_MAX)) begin
         mem_r[ptr_r] <= wdata;
      end
   end

   // Read port returns 0 when nothing is stored.
   always_comb begin
      rd_idx_s = ptr_r - PW'(1);
      if (ptr_r == {PW{1'b0}}) begin
         rdata = {WIDTH{1'b0}};
      end else begin
         rdata = mem_r[rd_idx_s];
      end
   end

endmodule

// File: rtl/operand_stack.sv
// Operand stack with top/pen held in registers and deeper entries in stack_storage.
module operand_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       start,
   input  stk_op_t                    op,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           top,
   output logic [WIDTH-1:0]           pen,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] top_nxt_s;
   logic [WIDTH-1:0] pen_nxt_s;
   logic [WIDTH-1:0] rdata_s;
   logic [CW-1:0]    count_nxt_s;
   logic             ovf_set_s;
   logic             unf_set_s;
   logic             st_push_s;
   logic             st_pop_s;
   logic             has1_s;
   logic             has2_s;
   logic             has3_s;
   logic             room_s;

   stack_storage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk   (clk),
      .clr   (start),
      .push  (st_push_s),
      .pop   (st_pop_s),
      .wdata (pen),
      .rdata (rdata_s)
   );

   // Next-state decode; storage only moves when pen has a real entry to spill or refill from.
   always_comb begin
      top_nxt_s   = top;
      pen_nxt_s   = pen;
      count_nxt_s = count;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      st_push_s   = 1'b0;
      st_pop_s    = 1'b0;
      has1_s      = (count >= CW'(1));
      has2_s      = (count >= CW'(2));
      has3_s      = (count >= CW'(3));
      room_s      = (count < CW'(DEPTH));
      case (op)
         PUSH: begin
            if (room_s) begin
               top_nxt_s   = din;
               pen_nxt_s   = top;
               count_nxt_s = count + CW'(1);
               st_push_s   = has2_s;
            end else begin
               ovf_set_s = 1'b1;
            end
         end
         POP: begin
            if (has1_s) begin
               top_nxt_s   = pen;
               pen_nxt_s   = has3_s ? rdata_s : {WIDTH{1'b0}};
               count_nxt_s = count - CW'(1);
               st_pop_s    = has3_s;
            end else begin
               unf_set_s = 1'b1;
            end
         end
         BINOP: begin
            if (has2_s) begin
               top_nxt_s   = din;
               pen_nxt_s   = has3_s ? rdata_s : {WIDTH{1'b0}};
               count_nxt_s = count - CW'(1);
               st_pop_s    = has3_s;
            end else begin
               unf_set_s = 1'b1;
            end
         end
         REPL: begin
            if (has1_s) begin
               top_nxt_s = din;
            end else begin
               unf_set_s = 1'b1;
            end
         end
         DUP: begin
            if (!has1_s) begin
               unf_set_s = 1'b1;
            end else if (!room_s) begin
               ovf_set_s = 1'b1;
            end else begin
               pen_nxt_s   = top;
               count_nxt_s = count + CW'(1);
               st_push_s   = has2_s;
            end
         end
         SWAP: begin
            if (has2_s) begin
               top_nxt_s = pen;
               pen_nxt_s = top;
            end else begin
               unf_set_s = 1'b1;
            end
         end
         default: begin
            top_nxt_s = top;
         end
      endcase
   end

   // State and status registers; start overrides any op.
   always_ff @(posedge clk) begin
      if (start) begin
         top       <= {WIDTH{1'b0}};
         pen       <= {WIDTH{1'b0}};
         count     <= {CW{1'b0}};
         empty     <= 1'b1;
         full      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         top       <= top_nxt_s;
         pen       <= pen_nxt_s;
         count     <= count_nxt_s;
         empty     <= (count_nxt_s == {CW{1'b0}});
         full      <= (count_nxt_s == CW'(DEPTH));
         overflow  <= overflow | ovf_set_s;
         underflow <= underflow | unf_set_s;
      end
   end

endmodule

// File: tb/tb_operand_stack.sv
// Directed and random checks of operand_stack (WIDTH=8, DEPTH=4) against a queue model.
module tb_operand_stack;
   import stack_pkg::*;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk;
   logic         start;
   stk_op_t      op;
   logic [W-1:0] din;
   logic [W-1:0] top;
   logic [W-1:0] pen;
   logic [2:0]   count;
   logic         empty;
   logic         full;
   logic         overflow;
   logic         underflow;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] mq[$];
   logic         m_ovf;
   logic         m_unf;

   operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .start     (start),
      .op        (op),
      .din       (din),
      .top       (top),
      .pen       (pen),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input stk_op_t o, input logic [W-1:0] d);
      logic [W-1:0] t;
      case (o)
         PUSH:  if (mq.size() < D) mq.push_front(d); else m_ovf = 1'b1;
         POP:   if (mq.size() >= 1) t = mq.pop_front(); else m_unf = 1'b1;
         BINOP: if (mq.size() >= 2) begin
                   t = mq.pop_front(); t = mq.pop_front(); mq.push_front(d);
                end else m_unf = 1'b1;
         REPL:  if (mq.size() >= 1) mq[0] = d; else m_unf = 1'b1;
         DUP:   if (mq.size() == 0) m_unf = 1'b1;
                else if (mq.size() >= D) m_ovf = 1'b1;
                else mq.push_front(mq[0]);
         SWAP:  if (mq.size() >= 2) begin
                   t = mq[0]; mq[0] = mq[1]; mq[1] = t;
                end else m_unf = 1'b1;
         default: ;
      endcase
   endtask

   task automatic apply(input stk_op_t o, input logic [W-1:0] d);
      @(negedge clk);
      op  = o;
      din = d;
      @(posedge clk);
      #1;
      model_step(o, d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      start = 1'b1;
      op    = PUSH;
      din   = 8'h77;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = NOP;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic check_model(input string tag);
      logic [W-1:0] et;
      logic [W-1:0] ep;
      et = (mq.size() > 0) ? mq[0] : 8'h00;
      ep = (mq.size() > 1) ? mq[1] : 8'h00;
      check({tag, ".top"}, 32'(top), 32'(et));
      check({tag, ".pen"}, 32'(pen), 32'(ep));
      check({tag, ".count"}, 32'(count), 32'(mq.size()));
      check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
      check({tag, ".full"}, 32'(full), 32'(mq.size() == D));
      check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
   endtask

   initial begin
      start = 1'b1;
      op    = NOP;
      din   = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check("rst.count", 32'(count), 32'd0);
      check("rst.top", 32'(top), 32'd0);
      check("rst.pen", 32'(pen), 32'd0);
      check("rst.empty", 32'(empty), 32'd1);
      check("rst.full", 32'(full), 32'd0);
      check("rst.flags", 32'({overflow, underflow}), 32'd0);

      // Fill to full, then one push too many.
      apply(PUSH, 8'h11);
      check("push1.top", 32'(top), 32'h11);
      apply(PUSH, 8'h22);
      apply(PUSH, 8'h33);
      apply(PUSH, 8'h44);
      check("fill.top", 32'(top), 32'h44);
      check("fill.pen", 32'(pen), 32'h33);
      check("fill.count", 32'(count), 32'd4);
      check("fill.full", 32'(full), 32'd1);
      apply(PUSH, 8'h55);
      check("ovf.top", 32'(top), 32'h44);
      check("ovf.pen", 32'(pen), 32'h33);
      check("ovf.count", 32'(count), 32'd4);
      check("ovf.flag", 32'(overflow), 32'd1);

      // Drain, then one pop too many.
      apply(POP, 8'h00);
      check("pop1.top", 32'(top), 32'h33);
      check("pop1.pen", 32'(pen), 32'h22);
      apply(POP, 8'h00);
      check("pop2.top", 32'(top), 32'h22);
      check("pop2.pen", 32'(pen), 32'h11);
      apply(POP, 8'h00);
      check("pop3.top", 32'(top), 32'h11);
      check("pop3.pen", 32'(pen), 32'h00);
      apply(POP, 8'h00);
      check("pop4.top", 32'(top), 32'h00);
      check("pop4.count", 32'(count), 32'd0);
      check("pop4.empty", 32'(empty), 32'd1);
      apply(POP, 8'h00);
      check("unf.flag", 32'(underflow), 32'd1);
      check("unf.count", 32'(count), 32'd0);
      check("unf.ovf_sticky", 32'(overflow), 32'd1);

      // Binop write-back, then swap refused with one operand.
      do_reset();
      apply(PUSH, 8'h03);
      apply(PUSH, 8'h05);
      apply(BINOP, 8'h08);
      check("binop.top", 32'(top), 32'h08);
      check("binop.pen", 32'(pen), 32'h00);
      check("binop.count", 32'(count), 32'd1);
      check("binop.unf", 32'(underflow), 32'd0);
      apply(SWAP, 8'h00);
      check("swap1.unf", 32'(underflow), 32'd1);
      check("swap1.top", 32'(top), 32'h08);
      check("swap1.count", 32'(count), 32'd1);

      // Dup / swap / repl.
      do_reset();
      apply(PUSH, 8'hA0);
      apply(DUP, 8'h00);
      check("dup.pen", 32'(pen), 32'hA0);
      check("dup.count", 32'(count), 32'd2);
      apply(SWAP, 8'h00);
      apply(REPL, 8'h0F);
      check("repl.top", 32'(top), 32'h0F);
      check("repl.pen", 32'(pen), 32'hA0);
      check("repl.count", 32'(count), 32'd2);

      // Start mid-sequence wins over a simultaneous push.
      do_reset();
      apply(PUSH, 8'h01);
      apply(PUSH, 8'h02);
      apply(PUSH, 8'h03);
      apply(PUSH, 8'h04);
      apply(PUSH, 8'h05);
      check("pre.ovf", 32'(overflow), 32'd1);
      do_reset();
      check("mid.count", 32'(count), 32'd0);
      check("mid.top", 32'(top), 32'd0);
      check("mid.pen", 32'(pen), 32'd0);
      check("mid.flags", 32'({overflow, underflow}), 32'd0);
      apply(PUSH, 8'h09);
      check("post.top", 32'(top), 32'h09);
      check("post.pen", 32'(pen), 32'h00);
      check("post.count", 32'(count), 32'd1);

      // Random op stream against the queue model, with occasional resets.
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            apply(stk_op_t'(3'($urandom_range(0, 7))), 8'($urandom_range(0, 255)));
         end
         check_model("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
